// File: rtl/set_assoc_cache.sv
// Read-only N-way set-associative byte cache with true-LRU replacement,
// flush, hit/miss statistics and a blocking line refill from main memory.
module set_assoc_cache #(
  parameter int ADDR_W   = 12,
  parameter int OFFSET_W = 4,
  parameter int SET_W    = 2,
  parameter int WAY_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       flush,
  output logic                       busy,
  output logic                       resp_valid,
  output logic                       hit,
  output logic [7:0]                 byte_out,
  output logic [(8<<OFFSET_W)-1:0]   line_out,
  output logic                       mem_req,
  output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
  input  logic                       mem_ready,
  input  logic [(8<<OFFSET_W)-1:0]   mem_line,
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count
);
  localparam int LINE_W = 8 << OFFSET_W;
  localparam int TAG_W  = ADDR_W - SET_W - OFFSET_W;
  localparam int SETS   = 1 << SET_W;
  localparam int WAYS   = 1 << WAY_W;
  localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;
  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  logic [WAYS-1:0]   valid [SETS];
  ages_t             age   [SETS];
  logic [TAG_W-1:0]  tags  [SETS][WAYS];
  logic [LINE_W-1:0] lines [SETS][WAYS];

  logic [TAG_W-1:0]    tag_q;
  logic [SET_W-1:0]    set_q;
  logic [OFFSET_W-1:0] off_q;
  assign {tag_q, set_q, off_q} = addr_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [LINE_W-1:0] l,
                                          input logic [OFFSET_W-1:0] k);
    logic [LINE_W-1:0] sh;
    sh = l >> {k, 3'b000};
    return sh[7:0];
  endfunction

  // Accessed way becomes youngest; only ways younger than it age by one,
  // so the set's ages stay a permutation of 0..WAYS-1.
  function automatic ages_t lru_touch(input ages_t a, input logic [WAY_W-1:0] w);
    ages_t r;
    r = a;
    for (int i = 0; i < WAYS; i++)
      if (a[i] < a[w]) r[i] = a[i] + 1'b1;
    r[w] = '0;
    return r;
  endfunction

  function automatic ages_t ages_init();
    ages_t r;
    for (int i = 0; i < WAYS; i++) r[i] = WAY_W'(i);
    return r;
  endfunction

  logic             hit_any;
  logic             inv_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vict_way;

  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    inv_any  = 1'b0;
    vict_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid[set_q][w] && tags[set_q][w] == tag_q) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++)
      if (age[set_q][w] == OLDEST) vict_way = WAY_W'(w);
    // A free way always wins over evicting the oldest line.
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_any && !valid[set_q][w]) begin
        inv_any  = 1'b1;
        vict_way = WAY_W'(w);
      end
    end
  end

  assign busy       = (state != IDLE);
  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      byte_out   <= '0;
      line_out   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        age[s]   <= ages_init();
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) begin
              valid[s] <= '0;
              age[s]   <= ages_init();
            end
          end else if (req) begin
            addr_q <= addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_any) begin
            resp_valid <= 1'b1;
            hit        <= 1'b1;
            line_out   <= lines[set_q][hit_way];
            byte_out   <= byte_sel(lines[set_q][hit_way], off_q);
            age[set_q] <= lru_touch(age[set_q], hit_way);
            hit_cnt    <= sat_inc(hit_cnt);
            state      <= IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {tag_q, set_q};
            miss_cnt <= sat_inc(miss_cnt);
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            valid[set_q][vict_way] <= 1'b1;
            age[set_q]             <= lru_touch(age[set_q], vict_way);
            resp_valid             <= 1'b1;
            hit                    <= 1'b0;
            line_out               <= mem_line;
            byte_out               <= byte_sel(mem_line, off_q);
            mem_req                <= 1'b0;
            state                  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) begin
      lines[set_q][vict_way] <= mem_line;
      tags[set_q][vict_way]  <= tag_q;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: scoreboarded responses, refill handshake,
// LRU eviction, flush, reset during refill, busy rejection and saturation.
`timescale 1ns/1ps
module tb_set_assoc_cache;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req = 1'b0;
  logic         flush = 1'b0;
  logic         mem_ready = 1'b0;
  logic [11:0]  addr = '0;
  logic [127:0] mem_line = '0;
  logic         busy, resp_valid, hit, mem_req;
  logic [7:0]   byte_out, mem_addr;
  logic [127:0] line_out;
  logic [15:0]  hit_count, miss_count;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_hits = '0;
  logic [15:0] exp_misses = '0;

  typedef struct {
    logic         h;
    logic [7:0]   b;
    logic [127:0] l;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .flush(flush),
    .busy(busy), .resp_valid(resp_valid), .hit(hit), .byte_out(byte_out),
    .line_out(line_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_line(mem_line),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Memory model: byte k of line la is the low 8 bits of {la, k}.
  function automatic logic [127:0] mk_line(input logic [7:0] la);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = {la[3:0], 4'(k)};
    return r;
  endfunction

  function automatic logic [7:0] byte_of(input logic [11:0] a);
    logic [127:0] l;
    l = mk_line(a[11:4]);
    return l[8*int'(a[3:0]) +: 8];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got hit=%0b byte=%h, want no response", hit, byte_out);
      end else begin
        e = sb.pop_front();
        if (hit !== e.h || byte_out !== e.b || line_out !== e.l) begin
          miscompares++;
          $display("FAIL resp: got hit=%0b byte=%h line=%h, want hit=%0b byte=%h line=%h",
                   hit, byte_out, line_out, e.h, e.b, e.l);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "bench time limit");
  end

  task automatic do_reset();
    req = 1'b0;
    flush = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_hits = '0;
    exp_misses = '0;
  endtask

  task automatic serve_refill(input logic [7:0] la, input int delay);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (mem_req !== 1'b1 && i < 10);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL mem_req_timeout: mem_req=%b after %0d cycles, want 1", mem_req, i);
      return;
    end
    vectors++;
    if (mem_addr !== la) begin
      miscompares++;
      $display("FAIL mem_addr: got %h, want %h", mem_addr, la);
    end
    repeat (delay) begin
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL mem_req_hold: mem_req=%b busy=%b, want 1 1", mem_req, busy);
      end
    end
    mem_ready = 1'b1;
    mem_line = mk_line(la);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mem_line = {4{$urandom}};
    req = 1'b0;
    flush = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mem_req_drop: mem_req=%b busy=%b, want 0 0", mem_req, busy);
    end
  endtask

  // One request; poke keeps req (addr 0x010) and flush high while busy.
  task automatic access(input logic [11:0] a, input bit exp_hit, input int delay, input bit poke);
    int n;
    int want_n;
    sb.push_back('{exp_hit, byte_of(a), mk_line(a[11:4])});
    if (exp_hit) begin
      if (exp_hits != 16'hFFFF) exp_hits++;
    end else begin
      if (exp_misses != 16'hFFFF) exp_misses++;
    end
    @(posedge clk);
    #1;
    req = 1'b1;
    addr = a;
    @(posedge clk);
    #1;
    if (poke) begin
      addr = 12'h010;
      flush = 1'b1;
    end else begin
      req = 1'b0;
    end
    if (!exp_hit) serve_refill(a[11:4], delay);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (sb.size() != 0 && n < 20);
    req = 1'b0;
    flush = 1'b0;
    want_n = exp_hit ? 2 : 1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL resp_timeout addr=%h: %0d responses outstanding, want 0", a, sb.size());
      sb.delete();
    end else if (n != want_n) begin
      miscompares++;
      $display("FAIL latency addr=%h: got %0d cycles, want %0d", a, n, want_n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, resp_valid, hit, mem_req} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/resp_valid/hit/mem_req=%b, want 0000",
               {busy, resp_valid, hit, mem_req});
    end
    vectors++;
    if (byte_out !== 8'h00 || line_out !== '0 || mem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: byte=%h line=%h mem_addr=%h, want zeros", byte_out, line_out, mem_addr);
    end
    vectors++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_counts: hits=%h misses=%h, want 0 0", hit_count, miss_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_cold_miss_hit();
    do_reset();
    access(12'h000, 1'b0, 3, 1'b0);
    access(12'h00F, 1'b1, 0, 1'b0);
    vectors++;
    if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
      miscompares++;
      $display("FAIL cold_counts: hits=%0d misses=%0d, want 1 1", hit_count, miss_count);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (hit !== 1'b1 || byte_out !== 8'h0F || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL output_hold: hit=%b byte=%h resp_valid=%b, want 1 0f 0", hit, byte_out, resp_valid);
    end
  endtask

  task automatic test_lru();
    do_reset();
    access(12'h000, 1'b0, 1, 1'b0);
    access(12'h040, 1'b0, 0, 1'b0);
    access(12'h080, 1'b0, 2, 1'b0);
    access(12'h0C0, 1'b0, 1, 1'b0);
    access(12'h000, 1'b1, 0, 1'b0);
    access(12'h10A, 1'b0, 1, 1'b0);
    access(12'h000, 1'b1, 0, 1'b0);
    access(12'h040, 1'b0, 1, 1'b0);
    access(12'h0C7, 1'b1, 0, 1'b0);
    access(12'h080, 1'b0, 1, 1'b0);
    vectors++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      miscompares++;
      $display("FAIL lru_counts: hits=%0d misses=%0d, want %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_flush();
    @(posedge clk);
    #1;
    req = 1'b1;
    flush = 1'b1;
    addr = 12'h000;
    @(posedge clk);
    #1;
    req = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_req_ignored: busy=%b, want 0", busy);
    end
    vectors++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      miscompares++;
      $display("FAIL flush_counts: hits=%0d misses=%0d, want %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end
    access(12'h000, 1'b0, 1, 1'b0);
    access(12'h0C0, 1'b0, 0, 1'b0);
    access(12'h000, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_refill();
    int i;
    do_reset();
    access(12'h040, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    req = 1'b1;
    addr = 12'h000;
    @(posedge clk);
    #1;
    req = 1'b0;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (mem_req !== 1'b1 && i < 10);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_mem_req: mem_req=%b, want 1", mem_req);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    mem_ready = 1'b1;
    mem_line = mk_line(8'h00);
    #1;
    vectors++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_drop: mem_req=%b busy=%b, want 0 0", mem_req, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_hits = '0;
    exp_misses = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_quiet: resp_valid=%b busy=%b, want 0 0", resp_valid, busy);
      end
    end
    mem_ready = 1'b0;
    vectors++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      miscompares++;
      $display("FAIL reset_mid_counts: hits=%0d misses=%0d, want 0 0", hit_count, miss_count);
    end
    access(12'h040, 1'b0, 1, 1'b0);
    access(12'h000, 1'b0, 2, 1'b0);
  endtask

  task automatic test_busy_reject();
    access(12'h000, 1'b1, 0, 1'b1);
    access(12'h0C0, 1'b0, 2, 1'b1);
    vectors++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      miscompares++;
      $display("FAIL busy_counts: hits=%0d misses=%0d, want %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end
    access(12'h010, 1'b0, 1, 1'b0);
    access(12'h000, 1'b1, 0, 1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    access(12'h000, 1'b0, 0, 1'b0);
    @(negedge clk);
    force dut.hit_cnt = 16'hFFFD;
    force dut.miss_cnt = 16'hFFFF;
    #1;
    release dut.hit_cnt;
    release dut.miss_cnt;
    exp_hits = 16'hFFFD;
    exp_misses = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      access(12'h000, 1'b1, 0, 1'b0);
      vectors++;
      if (hit_count !== exp_hits) begin
        miscompares++;
        $display("FAIL hit_saturation step %0d: got %h, want %h", k, hit_count, exp_hits);
      end
    end
    access(12'h040, 1'b0, 0, 1'b0);
    vectors++;
    if (miss_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL miss_saturation: got %h, want ffff", miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss_hit();
    test_lru();
    test_flush();
    test_reset_mid_refill();
    test_busy_reject();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
